// File: rtl/floating_point_to_integer.sv
// -----------------------------------------------------------------------------
// floating_point_to_integer
//
// Converts an IEEE-754 single-precision operand into a two's-complement signed
// integer, truncating toward zero like a C cast. Alignment is done one bit per
// clock by a small IDLE/SHIFT/DONE state machine.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds floating_in steady while valid_in is high; the result
// and flags are held steady while valid_out is high and ready_in is low.
//
// Ports
//   clk_in       clock, all state on the rising edge
//   rst_n_in     asynchronous active-low reset
//   valid_in     floating_in is valid
//   ready_out    block can accept an operand (IDLE only)
//   floating_in  {sign, exponent, mantissa}
//   valid_out    integer_out and flags are valid (DONE only)
//   ready_in     consumer accepts the result
//   integer_out  signed integer result
//   overflow_out magnitude out of range or +/-inf, result saturated
//   invalid_out  operand was NaN
//   state_out    current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module floating_point_to_integer #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8,
  parameter int INT_WIDTH  = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] floating_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [INT_WIDTH-1:0]  integer_out,
  output logic                  overflow_out,
  output logic                  invalid_out,
  output logic [1:0]            state_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BIAS = (1 << (EXPO_WIDTH - 1)) - 1;

  // Exponent-domain constants, signed and one bit wider than the exponent.
  localparam logic signed [EXPO_WIDTH:0] BIAS_S  = (EXPO_WIDTH + 1)'(BIAS);
  localparam logic signed [EXPO_WIDTH:0] MENT_S  = (EXPO_WIDTH + 1)'(MENT_WIDTH);
  localparam logic signed [EXPO_WIDTH:0] E_MAX_S = (EXPO_WIDTH + 1)'(INT_WIDTH - 2);
  localparam logic signed [EXPO_WIDTH:0] E_MIN_S = (EXPO_WIDTH + 1)'(INT_WIDTH - 1);

  localparam logic [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

  state_t                  state;
  logic [INT_WIDTH:0]      acc;
  logic [EXPO_WIDTH:0]     count;
  logic                    shift_left_q;
  logic                    sign_q;

  // Operand decode, only meaningful in the accept cycle.
  logic                    sign_w;
  logic [EXPO_WIDTH-1:0]   expo_w;
  logic [MENT_WIDTH-1:0]   ment_w;
  logic                    ment_zero;
  logic                    expo_max;
  logic signed [EXPO_WIDTH:0] e_unb;
  logic                    is_nan;
  logic                    is_inf;
  logic                    is_tiny;
  logic                    is_huge;
  logic                    is_int_min;
  logic                    shift_left_w;
  logic signed [EXPO_WIDTH:0] shift_amt;
  logic                    accept;

  assign sign_w    = floating_in[DATA_WIDTH-1];
  assign expo_w    = floating_in[DATA_WIDTH-2 -: EXPO_WIDTH];
  assign ment_w    = floating_in[MENT_WIDTH-1:0];
  assign ment_zero = (ment_w == '0);
  assign expo_max  = &expo_w;
  assign e_unb     = $signed({1'b0, expo_w}) - BIAS_S;

  assign is_nan     = expo_max & ~ment_zero;
  assign is_inf     = expo_max & ment_zero;
  assign is_tiny    = e_unb[EXPO_WIDTH];           // e < 0: zero, denormal, |x| < 1
  assign is_huge    = (e_unb > E_MAX_S);
  // -2^(INT_WIDTH-1) is representable even though its exponent is out of range.
  assign is_int_min = sign_w & (e_unb == E_MIN_S) & ment_zero;

  // Binary point sits MENT_WIDTH bits up in the accumulator; move it to bit 0.
  assign shift_left_w = (e_unb > MENT_S);
  assign shift_amt    = shift_left_w ? (e_unb - MENT_S) : (MENT_S - e_unb);

  assign accept    = valid_in & (state == IDLE);
  assign ready_out = (state == IDLE);
  assign valid_out = (state == DONE);
  assign state_out = state;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      shift_left_q <= 1'b0;
      sign_q       <= 1'b0;
      integer_out  <= '0;
      overflow_out <= 1'b0;
      invalid_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= sign_w;
            // Hidden bit is set for every non-zero biased exponent.
            acc    <= (INT_WIDTH + 1)'({expo_w != '0, ment_w});
            if (is_nan) begin
              integer_out  <= INT_MIN;
              overflow_out <= 1'b0;
              invalid_out  <= 1'b1;
              state        <= DONE;
            end else if (is_inf) begin
              integer_out  <= sign_w ? INT_MIN : INT_MAX;
              overflow_out <= 1'b1;
              invalid_out  <= 1'b0;
              state        <= DONE;
            end else if (is_tiny) begin
              integer_out  <= '0;
              overflow_out <= 1'b0;
              invalid_out  <= 1'b0;
              state        <= DONE;
            end else if (is_huge) begin
              integer_out  <= sign_w ? INT_MIN : INT_MAX;
              overflow_out <= ~is_int_min;
              invalid_out  <= 1'b0;
              state        <= DONE;
            end else begin
              count        <= $unsigned(shift_amt);
              shift_left_q <= shift_left_w;
              overflow_out <= 1'b0;
              invalid_out  <= 1'b0;
              state        <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (count != '0) begin
            // Right shifts drop fraction bits, which is truncation toward zero
            // on the magnitude.
            acc   <= shift_left_q ? {acc[INT_WIDTH-1:0], 1'b0}
                                  : {1'b0, acc[INT_WIDTH:1]};
            count <= count - 1'b1;
          end else begin
            integer_out <= sign_q ? -(acc[INT_WIDTH-1:0]) : acc[INT_WIDTH-1:0];
            state       <= DONE;
          end
        end

        DONE: begin
          if (ready_in) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_floating_point_to_integer.sv
// -----------------------------------------------------------------------------
// Bench for floating_point_to_integer: reset checks, a table of directed
// vectors, backpressure and ignored-valid sequence, reset in mid-shift, and
// randomized operands checked against an arithmetic reference model.
//
// Latency is measured as the number of rising edges after the accept edge
// before valid_out is seen high: special operands are already valid right after
// the accept edge (0), normal operands take |e-23|+1.
// -----------------------------------------------------------------------------
module tb_floating_point_to_integer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] floating_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] integer_out;
  logic        overflow_out;
  logic        invalid_out;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] f;
    logic [31:0] res;
    logic        ov;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  floating_point_to_integer dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .floating_in  (floating_in),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .integer_out  (integer_out),
    .overflow_out (overflow_out),
    .invalid_out  (invalid_out),
    .state_out    (state_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: value = sig * 2^(e-23), truncated, then range-checked.
  task automatic ref_model(input logic [31:0] f, output logic [31:0] res,
                           output logic ov, output logic inv, output int lat);
    bit     s;
    int     ex;
    int     e;
    longint sig;
    longint mag;
    longint lim;
    s   = f[31];
    ex  = int'(f[30:23]);
    e   = ex - 127;
    sig = longint'(f[22:0]) + ((ex != 0) ? 64'sd8388608 : 64'sd0);
    ov  = 1'b0;
    inv = 1'b0;
    lat = 0;
    if (ex == 255) begin
      if (f[22:0] != 0) begin
        res = 32'h8000_0000;
        inv = 1'b1;
      end else begin
        res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        ov  = 1'b1;
      end
    end else if (e < 0) begin
      res = 32'h0;
    end else if (e > 40) begin
      res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      ov  = 1'b1;
    end else begin
      if (e >= 23) mag = sig * (64'sd1 << (e - 23));
      else         mag = sig / (64'sd1 << (23 - e));
      lim = s ? 64'sd2147483648 : 64'sd2147483647;
      if (mag > lim) begin
        res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        ov  = 1'b1;
      end else begin
        res = 32'(s ? -mag : mag);
      end
      if (e <= 30) lat = ((e > 23) ? (e - 23) : (23 - e)) + 1;
    end
  endtask

  // ---------------- driver ----------------
  // Present one operand, measure latency, hold the result for 'hold' cycles
  // under backpressure, then complete the output handshake.
  task automatic run_conv(input string name, input logic [31:0] f, input logic [31:0] exp_res,
                          input logic exp_ov, input logic exp_inv, input int exp_lat,
                          input int hold);
    int guard;
    int lat;
    logic [31:0] res;
    @(negedge clk_in);
    floating_in = f;
    valid_in    = 1'b1;
    guard = 0;
    while (!ready_out && guard < 50) begin
      @(negedge clk_in);
      guard++;
    end
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    lat = 0;
    while (!valid_out && lat < 100) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    if (!valid_out) begin
      chk({name, "_timeout"}, 32'(valid_out), 32'h1);
    end else begin
      res = integer_out;
      chk({name, "_res"}, integer_out, exp_res);
      chk({name, "_ov"}, 32'(overflow_out), 32'(exp_ov));
      chk({name, "_inv"}, 32'(invalid_out), 32'(exp_inv));
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk_in);
        #1;
        chk({name, "_hold_res"}, integer_out, res);
        chk({name, "_hold_valid"}, 32'(valid_out), 32'h1);
      end
      @(negedge clk_in);
      ready_in = 1'b1;
      @(posedge clk_in);
      #1;
      ready_in = 1'b0;
      chk({name, "_ready_back"}, 32'(ready_out), 32'h1);
      chk({name, "_valid_drop"}, 32'(valid_out), 32'h0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] f;
    logic [31:0] r;
    logic        o;
    logic        n;
    int          l;
    int          guard;

    rst_n_in    = 1'b0;
    valid_in    = 1'b0;
    ready_in    = 1'b0;
    floating_in = 32'h0;
    repeat (3) @(negedge clk_in);
    chk("rst_ready", 32'(ready_out), 32'h1);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_int", integer_out, 32'h0);
    chk("rst_ov", 32'(overflow_out), 32'h0);
    chk("rst_inv", 32'(invalid_out), 32'h0);
    rst_n_in = 1'b1;

    // Directed table: operand, result, overflow, invalid, latency.
    vecs.push_back('{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 24});
    vecs.push_back('{32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 23});
    vecs.push_back('{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 0});
    vecs.push_back('{32'h4E80_0000, 32'h4000_0000, 1'b0, 1'b0, 8});
    vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0});
    vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 0});
    vecs.push_back('{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 0});
    vecs.push_back('{32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1, 0});
    vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 0});
    vecs.push_back('{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 0});
    vecs.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 0});
    vecs.push_back('{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 8});
    vecs.push_back('{32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 24});
    vecs.push_back('{32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 18});

    foreach (vecs[i]) begin
      run_conv($sformatf("vec%0d", i), vecs[i].f, vecs[i].res, vecs[i].ov,
               vecs[i].inv, vecs[i].lat, i % 3);
    end

    // Backpressure with ignored valid_in pulses during SHIFT and DONE.
    @(negedge clk_in);
    floating_in = 32'h42F6_0000;   // 123.0
    valid_in    = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    floating_in = 32'h3F80_0000;
    valid_in    = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    chk("bp_busy_ready", 32'(ready_out), 32'h0);
    guard = 0;
    while (!valid_out && guard < 100) begin
      @(posedge clk_in);
      #1;
      guard++;
    end
    chk("bp_valid", 32'(valid_out), 32'h1);
    chk("bp_res", integer_out, 32'h0000_007B);
    floating_in = 32'h7FC0_0000;
    valid_in    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in);
      #1;
      chk("bp_hold_res", integer_out, 32'h0000_007B);
      chk("bp_hold_valid", 32'(valid_out), 32'h1);
      chk("bp_hold_inv", 32'(invalid_out), 32'h0);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    ready_in = 1'b0;
    chk("bp_ready_back", 32'(ready_out), 32'h1);
    chk("bp_valid_drop", 32'(valid_out), 32'h0);
    @(posedge clk_in);
    #1;
    chk("bp_still_idle", 32'(state_out), 32'h0);
    chk("bp_no_capture", 32'(valid_out), 32'h0);

    // Reset in the middle of a 1.0 conversion.
    @(negedge clk_in);
    floating_in = 32'h3F80_0000;
    valid_in    = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready_out), 32'h1);
    chk("mid_rst_valid", 32'(valid_out), 32'h0);
    chk("mid_rst_int", integer_out, 32'h0);
    chk("mid_rst_ov", 32'(overflow_out), 32'h0);
    chk("mid_rst_inv", 32'(invalid_out), 32'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    run_conv("after_rst", 32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 21, 0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 300; i++) begin
      f = $urandom;
      if ($urandom_range(0, 1) == 1) f[30:23] = 8'($urandom_range(118, 160));
      ref_model(f, r, o, n, l);
      run_conv($sformatf("rnd%0d_%h", i, f), f, r, o, n, l, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
